dl_reset_ctrl: RTL and testbench

Parametrised ROM-download gate and core reset sequencer for arcade cores. It sits between `data_io` and the game core. It decodes the ioctl stream into up to `REGIONS` ROM write ports with region-relative addresses. It validates each download by checking for non-zero data and a minimum size. It holds the core in reset until a valid image exists, then releases it after a programmable settle period. This replaces the single "ROM seen" latch and OR-ed reset term with a sequenced, multi-region controller.

---
 rtl/dl_reset_pkg.sv | 19 +
 rtl/dl_region_decode.sv | 37 +++
 rtl/dl_reset_ctrl.sv | 164 ++++++++++++++++
 tb/tb_dl_reset_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_reset_pkg.sv
// Shared types and helpers for the ROM-download gate / core reset sequencer.
package dl_reset_pkg;

    localparam int unsigned IOCTL_AW = 25;

    typedef enum logic [2:0] {
        StEmpty,
        StLoading,
        StCheck,
        StHold,
        StRun
    } dl_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [IOCTL_AW-1:0] sat_inc(input logic [IOCTL_AW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dl_region_decode.sv
// Combinational ioctl address to one-hot region select and region-relative offset.
// Regions are contiguous: region 0 starts at 0, region i starts at REGION_END[i-1].
module dl_region_decode
    import dl_reset_pkg::*;
#(
    parameter int unsigned                 REGIONS    = 4,
    parameter int unsigned                 ADDR_W     = 14,
    parameter logic [REGIONS*IOCTL_AW-1:0] REGION_END = {4{25'd0}}
) (
    input  logic [IOCTL_AW-1:0] i_addr,
    output logic [REGIONS-1:0]  o_sel,
    output logic [ADDR_W-1:0]   o_offset
);

    logic [IOCTL_AW-1:0] w_lo;
    logic [IOCTL_AW-1:0] w_hi;
    logic [IOCTL_AW-1:0] w_diff;

    // Walk the ascending end table; at most one region can match.
    always_comb begin
        o_sel    = '0;
        o_offset = '0;
        w_lo     = '0;
        w_hi     = '0;
        w_diff   = '0;
        for (int i = 0; i < REGIONS; i++) begin
            w_hi = REGION_END[i*IOCTL_AW +: IOCTL_AW];
            if ((i_addr >= w_lo) && (i_addr < w_hi)) begin
                o_sel[i] = 1'b1;
                w_diff   = i_addr - w_lo;
                o_offset = w_diff[ADDR_W-1:0];
            end
            w_lo = w_hi;
        end
    end

endmodule

// File: rtl/dl_reset_ctrl.sv
// ROM-download gate and core reset sequencer: routes ioctl writes to region ports,
// validates the image and holds the core in reset until a settle period has elapsed.
module dl_reset_ctrl
    import dl_reset_pkg::*;
#(
    parameter int unsigned                 REGIONS     = 4,
    parameter int unsigned                 ADDR_W      = 14,
    parameter logic [7:0]                  DL_INDEX    = 8'd0,
    parameter logic [REGIONS*IOCTL_AW-1:0] REGION_END  = {4{25'd0}},
    parameter logic [IOCTL_AW-1:0]         MIN_BYTES   = 25'd1,
    parameter int unsigned                 HOLD_CYCLES = 1024
) (
    input  logic                i_clk_sys,
    input  logic                i_reset_n,
    input  logic                i_ioctl_downl,
    input  logic [7:0]          i_ioctl_index,
    input  logic                i_ioctl_wr,
    input  logic [IOCTL_AW-1:0] i_ioctl_addr,
    input  logic [7:0]          i_ioctl_dout,
    input  logic                i_user_reset,
    output logic                o_core_reset,
    output logic                o_rom_loaded,
    output logic                o_load_error,
    output logic [REGIONS-1:0]  o_region_wr,
    output logic [ADDR_W-1:0]   o_region_addr,
    output logic [7:0]          o_region_data,
    output logic [IOCTL_AW-1:0] o_byte_count
);

    localparam int unsigned      CNT_W     = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    dl_state_e           r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic [IOCTL_AW-1:0] r_byte_count, w_byte_count_d;
    logic                r_nonzero, w_nonzero_d;
    logic                r_rom_loaded, w_rom_loaded_d;
    logic                r_load_error, w_load_error_d;
    logic                r_core_reset;
    // Cleared by reset; set once no matching download is active, so a download that
    // was already running across a reset is never picked up halfway through.
    logic                r_armed;
    logic [REGIONS-1:0]  r_region_wr;
    logic [ADDR_W-1:0]   r_region_addr;
    logic [7:0]          r_region_data;

    logic                w_index_ok;
    logic                w_match;
    logic                w_start;
    logic                w_accept;
    logic [REGIONS-1:0]  w_sel;
    logic [ADDR_W-1:0]   w_offset;

    assign w_index_ok = (i_ioctl_index == DL_INDEX);
    assign w_match    = i_ioctl_downl & w_index_ok;
    assign w_start    = w_match & r_armed & ((r_state == StEmpty) | (r_state == StRun));
    // In LOADING the index alone qualifies a write, so a strobe coincident with the
    // falling download flag is still taken.
    assign w_accept   = i_ioctl_wr & w_index_ok & ((r_state == StLoading) | w_start);

    dl_region_decode #(
        .REGIONS    (REGIONS),
        .ADDR_W     (ADDR_W),
        .REGION_END (REGION_END)
    ) u_decode (
        .i_addr   (i_ioctl_addr),
        .o_sel    (w_sel),
        .o_offset (w_offset)
    );

    // Next-state, validation and byte accounting.
    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_rom_loaded_d = r_rom_loaded;
        w_load_error_d = r_load_error;
        w_byte_count_d = w_start ? '0 : r_byte_count;
        w_nonzero_d    = w_start ? 1'b0 : r_nonzero;

        if (w_start) begin
            w_state_d      = StLoading;
            w_rom_loaded_d = 1'b0;
            w_load_error_d = 1'b0;
        end

        case (r_state)
            StLoading: begin
                if (!w_match) w_state_d = StCheck;
            end
            StCheck: begin
                if (r_nonzero && (r_byte_count >= MIN_BYTES)) begin
                    w_state_d      = StHold;
                    w_rom_loaded_d = 1'b1;
                    w_cnt_d        = HOLD_LOAD;
                end else begin
                    w_state_d      = StEmpty;
                    w_rom_loaded_d = 1'b0;
                    w_load_error_d = 1'b1;
                end
            end
            StHold: begin
                if (i_user_reset) begin
                    w_cnt_d = HOLD_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_d = StRun;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StRun: begin
                if (!w_start && i_user_reset) begin
                    w_state_d = StHold;
                    w_cnt_d   = HOLD_LOAD;
                end
            end
            default: ;
        endcase

        if (w_accept) begin
            w_byte_count_d = sat_inc(w_byte_count_d);
            w_nonzero_d    = w_nonzero_d | (i_ioctl_dout != 8'd0);
        end
    end

    // State, status and write-port registers.
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StEmpty;
            r_cnt         <= '0;
            r_byte_count  <= '0;
            r_nonzero     <= 1'b0;
            r_rom_loaded  <= 1'b0;
            r_load_error  <= 1'b0;
            r_core_reset  <= 1'b1;
            r_armed       <= 1'b0;
            r_region_wr   <= '0;
            r_region_addr <= '0;
            r_region_data <= '0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_byte_count <= w_byte_count_d;
            r_nonzero    <= w_nonzero_d;
            r_rom_loaded <= w_rom_loaded_d;
            r_load_error <= w_load_error_d;
            r_core_reset <= (w_state_d != StRun);
            r_armed      <= r_armed | ~w_match;
            r_region_wr  <= w_accept ? w_sel : '0;
            if (w_accept) begin
                r_region_addr <= w_offset;
                r_region_data <= i_ioctl_dout;
            end
        end
    end

    assign o_core_reset  = r_core_reset;
    assign o_rom_loaded  = r_rom_loaded;
    assign o_load_error  = r_load_error;
    assign o_region_wr   = r_region_wr;
    assign o_region_addr = r_region_addr;
    assign o_region_data = r_region_data;
    assign o_byte_count  = r_byte_count;

endmodule

// File: tb/tb_dl_reset_ctrl.sv
// Directed bench for dl_reset_ctrl with a write scoreboard: two regions (0x2000, 0x4000).
module tb_dl_reset_ctrl;

    localparam int unsigned HOLD = 16;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_ioctl_downl;
    logic [7:0]  i_ioctl_index;
    logic        i_ioctl_wr;
    logic [24:0] i_ioctl_addr;
    logic [7:0]  i_ioctl_dout;
    logic        i_user_reset;
    logic        o_core_reset;
    logic        o_rom_loaded;
    logic        o_load_error;
    logic [1:0]  o_region_wr;
    logic [13:0] o_region_addr;
    logic [7:0]  o_region_data;
    logic [24:0] o_byte_count;

    always #5 clk = ~clk;

    dl_reset_ctrl #(
        .REGIONS     (2),
        .ADDR_W      (14),
        .DL_INDEX    (8'd0),
        .REGION_END  ({25'h4000, 25'h2000}),
        .MIN_BYTES   (25'd1),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .i_clk_sys     (clk),
        .i_reset_n     (i_reset_n),
        .i_ioctl_downl (i_ioctl_downl),
        .i_ioctl_index (i_ioctl_index),
        .i_ioctl_wr    (i_ioctl_wr),
        .i_ioctl_addr  (i_ioctl_addr),
        .i_ioctl_dout  (i_ioctl_dout),
        .i_user_reset  (i_user_reset),
        .o_core_reset  (o_core_reset),
        .o_rom_loaded  (o_rom_loaded),
        .o_load_error  (o_load_error),
        .o_region_wr   (o_region_wr),
        .o_region_addr (o_region_addr),
        .o_region_data (o_region_data),
        .o_byte_count  (o_byte_count)
    );

    typedef struct packed {
        logic [1:0]  wr;
        logic [13:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, strobes checked against the queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (o_region_wr != 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected_wr", {30'd0, o_region_wr}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_wr",   {30'd0, o_region_wr},   {30'd0, e.wr});
                chk("sb_addr", {18'd0, o_region_addr}, {18'd0, e.addr});
                chk("sb_data", {24'd0, o_region_data}, {24'd0, e.data});
            end
        end
    endtask

    // Drive one byte strobe; the expected region write is predicted from the address map.
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input logic last,
                           input logic expect_wr);
        logic [24:0] off;
        i_ioctl_addr = a;
        i_ioctl_dout = d;
        i_ioctl_wr   = 1'b1;
        if (last) i_ioctl_downl = 1'b0;
        if (expect_wr) begin
            if (a < 25'h2000) begin
                q.push_back({2'b01, a[13:0], d});
            end else if (a < 25'h4000) begin
                off = a - 25'h2000;
                q.push_back({2'b10, off[13:0], d});
            end
        end
        tick();
        i_ioctl_wr = 1'b0;
    endtask

    task automatic check_release(input string tag);
        for (int i = 1; i <= int'(HOLD); i++) begin
            tick();
            if (i == int'(HOLD) - 1) chk({tag, "_still_held"}, {31'd0, o_core_reset}, 32'd1);
            if (i == int'(HOLD))     chk({tag, "_released"},   {31'd0, o_core_reset}, 32'd0);
        end
    endtask

    initial begin
        i_reset_n     = 1'b0;
        i_ioctl_downl = 1'b0;
        i_ioctl_index = 8'd0;
        i_ioctl_wr    = 1'b0;
        i_ioctl_addr  = '0;
        i_ioctl_dout  = '0;
        i_user_reset  = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_core_reset",  {31'd0, o_core_reset}, 32'd1);
        chk("rst_rom_loaded",  {31'd0, o_rom_loaded}, 32'd0);
        chk("rst_load_error",  {31'd0, o_load_error}, 32'd0);
        chk("rst_region_wr",   {30'd0, o_region_wr},  32'd0);
        chk("rst_region_addr", {18'd0, o_region_addr}, 32'd0);
        chk("rst_region_data", {24'd0, o_region_data}, 32'd0);
        chk("rst_byte_count",  {7'd0, o_byte_count}, 32'd0);
        i_reset_n = 1'b1;
        tick();
        tick();

        // Full 0x4000-byte nonzero image, last strobe coincident with downl falling
        i_ioctl_downl = 1'b1;
        i_ioctl_index = 8'd0;
        tick();
        for (int a = 0; a < 'h4000; a++) begin
            wr_byte(25'(a), 8'((a % 255) + 1), (a == 'h3FFF), 1'b1);
            if (a == 'h1FFF) begin
                chk("r0_last_wr",   {30'd0, o_region_wr},  32'd1);
                chk("r0_last_addr", {18'd0, o_region_addr}, 32'h1FFF);
            end
            if (a == 'h2000) begin
                chk("r1_first_wr",   {30'd0, o_region_wr},  32'd2);
                chk("r1_first_addr", {18'd0, o_region_addr}, 32'd0);
            end
        end
        chk("dl1_byte_count", {7'd0, o_byte_count}, 32'h4000);
        chk("dl1_not_yet_loaded", {31'd0, o_rom_loaded}, 32'd0);
        tick();
        chk("dl1_rom_loaded", {31'd0, o_rom_loaded}, 32'd1);
        chk("dl1_load_error", {31'd0, o_load_error}, 32'd0);
        chk("dl1_core_held",  {31'd0, o_core_reset}, 32'd1);
        check_release("dl1");
        chk("dl1_sb_drained", q.size(), 32'd0);

        // Non-matching index in RUN is ignored
        i_ioctl_index = 8'd1;
        i_ioctl_downl = 1'b1;
        tick();
        for (int a = 0; a < 3; a++) wr_byte(25'(a), 8'h77, 1'b0, 1'b0);
        i_ioctl_downl = 1'b0;
        tick();
        i_ioctl_index = 8'd0;
        tick();
        chk("idx1_byte_count", {7'd0, o_byte_count}, 32'h4000);
        chk("idx1_core_run",   {31'd0, o_core_reset}, 32'd0);
        chk("idx1_rom_loaded", {31'd0, o_rom_loaded}, 32'd1);

        // user_reset pulse of 5 cycles
        i_user_reset = 1'b1;
        tick();
        chk("ureset_assert", {31'd0, o_core_reset}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        i_user_reset = 1'b0;
        check_release("ureset");

        // Download with a write beyond the last region
        i_ioctl_downl = 1'b1;
        tick();
        chk("dl2_rom_cleared", {31'd0, o_rom_loaded}, 32'd0);
        chk("dl2_core_held",   {31'd0, o_core_reset}, 32'd1);
        wr_byte(25'h0000, 8'hA5, 1'b0, 1'b1);
        wr_byte(25'h5000, 8'h11, 1'b1, 1'b1);
        chk("oob_byte_count", {7'd0, o_byte_count}, 32'd2);
        tick();
        chk("dl2_rom_loaded", {31'd0, o_rom_loaded}, 32'd1);
        check_release("dl2");

        // All-zero image fails validation
        i_ioctl_downl = 1'b1;
        tick();
        for (int a = 0; a < 'h100; a++) wr_byte(25'(a), 8'h00, (a == 'hFF), 1'b1);
        chk("zero_byte_count", {7'd0, o_byte_count}, 32'h100);
        tick();
        chk("zero_load_error", {31'd0, o_load_error}, 32'd1);
        chk("zero_rom_loaded", {31'd0, o_rom_loaded}, 32'd0);
        for (int i = 0; i < 2 * int'(HOLD); i++) tick();
        chk("zero_core_held", {31'd0, o_core_reset}, 32'd1);

        // Reset mid-download, released while downl still high
        i_ioctl_downl = 1'b1;
        tick();
        chk("dl3_error_cleared", {31'd0, o_load_error}, 32'd0);
        wr_byte(25'h0010, 8'h3C, 1'b0, 1'b1);
        wr_byte(25'h2010, 8'h3D, 1'b0, 1'b1);
        i_reset_n = 1'b0;
        #1;
        chk("midrst_region_wr",  {30'd0, o_region_wr},  32'd0);
        chk("midrst_byte_count", {7'd0, o_byte_count}, 32'd0);
        chk("midrst_core_reset", {31'd0, o_core_reset}, 32'd1);
        tick();
        tick();
        i_reset_n = 1'b1;
        for (int a = 0; a < 4; a++) wr_byte(25'(32 + a), 8'h55, 1'b0, 1'b0);
        chk("stale_byte_count", {7'd0, o_byte_count}, 32'd0);
        chk("stale_core_reset", {31'd0, o_core_reset}, 32'd1);
        chk("stale_rom_loaded", {31'd0, o_rom_loaded}, 32'd0);
        i_ioctl_downl = 1'b0;
        tick();
        tick();
        chk("stale_sb_drained", q.size(), 32'd0);

        // Fresh download after the reset loads normally
        i_ioctl_downl = 1'b1;
        tick();
        for (int a = 0; a < 16; a++) wr_byte(25'(a), 8'(a + 1), (a == 15), 1'b1);
        chk("dl4_byte_count", {7'd0, o_byte_count}, 32'd16);
        tick();
        chk("dl4_rom_loaded", {31'd0, o_rom_loaded}, 32'd1);
        check_release("dl4");
        chk("final_sb_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
